// File: rtl/cpu_pkg.sv
// Shared CPU control types: HI/LO sequencer state encoding and HI/LO source selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    WRITE,
    EXC
  } hilo_state_t;

  localparam logic HILO_SEL_MULT = 1'b0;
  localparam logic HILO_SEL_DIV  = 1'b1;

endpackage

// File: rtl/hilo_sequencer.sv
// Sequences one mult/div at a time: start pulse, fixed-latency wait, HI/LO commit,
// divide-by-zero trap and mfhi/mflo read interlock.
//
// state | meaning
// IDLE  | waiting for an operation from the control unit
// START | start pulse to the selected unit, latency counter loaded
// RUN   | counting down the unit latency
// WRITE | commit unit outputs into HI/LO, done pulse
// EXC   | divisor was zero, raise div_by_zero instead of starting
module hilo_sequencer
  import cpu_pkg::*;
#(
  parameter int LAT_MULT = 32,
  parameter int LAT_DIV  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_kind,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        abort,
  input  logic        hilo_read_req,
  output logic        mult_start,
  output logic        div_start,
  output logic        hi_write,
  output logic        lo_write,
  output logic        hilo_sel,
  output logic        div_by_zero,
  output logic        done,
  output logic        busy,
  output logic        hilo_stall
);

  localparam int LAT_MAX = (LAT_MULT > LAT_DIV) ? LAT_MULT : LAT_DIV;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(LAT_MULT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(LAT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  hilo_state_t      state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             kindQ;
  logic             accept;
  logic             startPhase, writePhase, excPhase;

  // Gated by reset so every output reads 0 while reset is held.
  assign op_ready = reset & (state == IDLE) & ~abort;
  assign accept   = op_valid & op_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      kindQ <= HILO_SEL_MULT;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) kindQ <= op_kind;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    startPhase = 1'b0;
    writePhase = 1'b0;
    excPhase   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = (op_kind == HILO_SEL_DIV && op_b == '0) ? EXC : START;
        end
      end
      START: begin
        startPhase = 1'b1;
        cntNext    = (kindQ == HILO_SEL_DIV) ? DIV_LOAD : MULT_LOAD;
        stateNext  = RUN;
      end
      RUN: begin
        cntNext = cnt - CNT_ONE;
        if (cnt == CNT_ONE) stateNext = WRITE;
      end
      WRITE: begin
        writePhase = 1'b1;
        stateNext  = IDLE;
      end
      EXC: begin
        excPhase  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (abort && state != IDLE) stateNext = IDLE;
  end

  // Abort kills side effects in the same cycle it is raised.
  assign mult_start  = startPhase & (kindQ == HILO_SEL_MULT) & ~abort;
  assign div_start   = startPhase & (kindQ == HILO_SEL_DIV) & ~abort;
  assign hi_write    = writePhase & ~abort;
  assign lo_write    = writePhase & ~abort;
  assign done        = writePhase & ~abort;
  assign div_by_zero = excPhase & ~abort;
  assign hilo_sel    = kindQ;
  assign busy        = (state != IDLE);
  assign hilo_stall  = hilo_read_req & busy;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Bench for hilo_sequencer: timeline model of each operation checked every cycle,
// plus directed scenarios with literal cycle expectations.
module tb_hilo_sequencer;

  localparam int LAT_MULT = 32;
  localparam int LAT_DIV  = 33;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_kind, abort, hilo_read_req;
  logic [31:0] op_b;
  logic        op_ready, mult_start, div_start, hi_write, lo_write;
  logic        hilo_sel, div_by_zero, done, busy, hilo_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_sequencer #(.LAT_MULT(LAT_MULT), .LAT_DIV(LAT_DIV)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_kind(op_kind), .op_b(op_b),
    .op_ready(op_ready), .abort(abort), .hilo_read_req(hilo_read_req),
    .mult_start(mult_start), .div_start(div_start), .hi_write(hi_write),
    .lo_write(lo_write), .hilo_sel(hilo_sel), .div_by_zero(div_by_zero),
    .done(done), .busy(busy), .hilo_stall(hilo_stall)
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: actual %0d required %0d", nm, $time, act, exp);
    end
  endtask

  // Model: an operation is the accept cycle plus its kind; everything else is
  // derived from its age in cycles.
  int cyc = 0;
  int mAcc = 0;
  bit mActive, mKind, mDbz, mSel;

  function automatic int lastRel();
    return mDbz ? 1 : 1 + (mKind ? LAT_DIV : LAT_MULT);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      mActive = 1'b0;
      mSel    = 1'b0;
    end else if (mActive) begin
      if (abort || (cyc - mAcc) >= lastRel()) mActive = 1'b0;
    end else if (op_valid && !abort) begin
      mActive = 1'b1;
      mAcc    = cyc;
      mKind   = op_kind;
      mDbz    = op_kind && (op_b == 32'd0);
      mSel    = op_kind;
    end
    cyc++;
  end

  always @(negedge clk) begin
    int rel;
    bit live, wr;
    rel  = cyc - mAcc;
    live = reset && mActive;
    wr   = live && !mDbz && !abort && rel == lastRel();
    chk("op_ready", op_ready, int'(reset && !mActive && !abort));
    chk("busy", busy, int'(live));
    chk("mult_start", mult_start, int'(live && !mDbz && !mKind && rel == 1 && !abort));
    chk("div_start", div_start, int'(live && !mDbz && mKind && rel == 1 && !abort));
    chk("hi_write", hi_write, int'(wr));
    chk("lo_write", lo_write, int'(wr));
    chk("done", done, int'(wr));
    chk("div_by_zero", div_by_zero, int'(live && mDbz && rel == 1 && !abort));
    chk("hilo_sel", hilo_sel, int'(reset && mSel));
    chk("hilo_stall", hilo_stall, int'(hilo_read_req && live));
  end

  // Directed scenario driver; traces are indexed by cycle relative to the scenario start.
  logic [63:0] msTr, dsTr, wrTr, loTr, dnTr, dbzTr, bzTr, rdTr, selTr, stTr;
  int offA, offB, abortAt, rdFrom, rdTo, rstFrom, rstTo;
  bit kA, kB;
  logic [31:0] bA, bB;

  task automatic clearCfg();
    offA = -1; offB = -1; abortAt = -1; rdFrom = -1; rdTo = -1; rstFrom = -1; rstTo = -1;
    kA = 1'b0; kB = 1'b0; bA = 32'd0; bB = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    msTr = '0; dsTr = '0; wrTr = '0; loTr = '0; dnTr = '0;
    dbzTr = '0; bzTr = '0; rdTr = '0; selTr = '0; stTr = '0;
    for (int r = 0; r <= n; r++) begin
      op_valid      = (r == offA) || (r == offB);
      op_kind       = (r == offB) ? kB : kA;
      op_b          = (r == offB) ? bB : bA;
      abort         = (r == abortAt);
      hilo_read_req = (rdFrom >= 0) && (r >= rdFrom) && (r <= rdTo);
      reset         = !((rstFrom >= 0) && (r >= rstFrom) && (r <= rstTo));
      @(negedge clk);
      msTr[r] = mult_start;  dsTr[r] = div_start;  wrTr[r] = hi_write;
      loTr[r] = lo_write;    dnTr[r] = done;       dbzTr[r] = div_by_zero;
      bzTr[r] = busy;        rdTr[r] = op_ready;   selTr[r] = hilo_sel;
      stTr[r] = hilo_stall;
      step();
    end
    op_valid = 1'b0; abort = 1'b0; hilo_read_req = 1'b0; reset = 1'b1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      step();
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    chk("wait_idle_bound", busy, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_kind = 1'b0; op_b = 32'd0;
    abort = 1'b0; hilo_read_req = 1'b0;
    clearCfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_op_ready", op_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_hilo_sel", hilo_sel, 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_op_ready", op_ready, 1);
    step();

    // Mult happy path
    clearCfg(); offA = 0; kA = 1'b0; bA = 32'd5;
    run(40);
    chk("mult_start_c1", msTr[1], 1);
    chk("mult_start_count", $countones(msTr), 1);
    chk("mult_hi_write_c33", wrTr[33], 1);
    chk("mult_hi_write_count", $countones(wrTr), 1);
    chk("mult_lo_write_c33", loTr[33], 1);
    chk("mult_done_c33", dnTr[33], 1);
    chk("mult_sel_c33", selTr[33], 0);
    chk("mult_busy_count", $countones(bzTr), 33);
    chk("mult_busy_c33", bzTr[33], 1);
    chk("mult_ready_c33", rdTr[33], 0);
    chk("mult_ready_c34", rdTr[34], 1);
    waitIdle();

    // Div happy path
    clearCfg(); offA = 0; kA = 1'b1; bA = 32'd7;
    run(40);
    chk("div_start_c1", dsTr[1], 1);
    chk("div_mult_start_never", $countones(msTr), 0);
    chk("div_write_c34", wrTr[34], 1);
    chk("div_write_count", $countones(wrTr), 1);
    chk("div_done_c34", dnTr[34], 1);
    chk("div_sel_c34", selTr[34], 1);
    chk("div_ready_c35", rdTr[35], 1);
    waitIdle();

    // Divide by zero
    clearCfg(); offA = 0; kA = 1'b1; bA = 32'd0;
    run(40);
    chk("dbz_c1", dbzTr[1], 1);
    chk("dbz_count", $countones(dbzTr), 1);
    chk("dbz_no_div_start", $countones(dsTr), 0);
    chk("dbz_no_hi_write", $countones(wrTr), 0);
    chk("dbz_no_lo_write", $countones(loTr), 0);
    chk("dbz_busy_c1", bzTr[1], 1);
    chk("dbz_busy_count", $countones(bzTr), 1);
    chk("dbz_ready_c1", rdTr[1], 0);
    chk("dbz_ready_c2", rdTr[2], 1);
    waitIdle();

    // Abort mid-mult, new mult offered right after
    clearCfg(); offA = 0; kA = 1'b0; bA = 32'd5; abortAt = 10; offB = 11; kB = 1'b0; bB = 32'd3;
    run(40);
    chk("abort_busy_c10", bzTr[10], 1);
    chk("abort_idle_c11", bzTr[11], 0);
    chk("abort_ready_c11", rdTr[11], 1);
    chk("abort_restart_c12", msTr[12], 1);
    chk("abort_start_count", $countones(msTr), 2);
    chk("abort_no_write", $countones(wrTr), 0);
    chk("abort_no_done", $countones(dnTr), 0);
    waitIdle();

    // Read interlock
    clearCfg(); offA = 0; kA = 1'b0; bA = 32'd5; rdFrom = 5; rdTo = 40;
    run(40);
    chk("stall_c4", stTr[4], 0);
    chk("stall_c5", stTr[5], 1);
    chk("stall_c33", stTr[33], 1);
    chk("stall_c34", stTr[34], 0);
    chk("stall_count", $countones(stTr), 29);
    chk("stall_write_c33", wrTr[33], 1);
    waitIdle();

    // Read interlock with abort in the WRITE cycle
    clearCfg(); offA = 0; kA = 1'b0; bA = 32'd5; rdFrom = 5; rdTo = 40; abortAt = 33;
    run(40);
    chk("wabort_no_write", $countones(wrTr), 0);
    chk("wabort_no_done", $countones(dnTr), 0);
    chk("wabort_stall_c33", stTr[33], 1);
    chk("wabort_stall_c34", stTr[34], 0);
    chk("wabort_ready_c34", rdTr[34], 1);
    waitIdle();

    // Back-to-back: div accepted in the first idle cycle after a mult
    clearCfg(); offA = 0; kA = 1'b0; bA = 32'd5; offB = 34; kB = 1'b1; bB = 32'd9;
    run(40);
    chk("b2b_write_c33", wrTr[33], 1);
    chk("b2b_ready_c34", rdTr[34], 1);
    chk("b2b_sel_c34", selTr[34], 0);
    chk("b2b_div_start_c35", dsTr[35], 1);
    chk("b2b_busy_c35", bzTr[35], 1);
    chk("b2b_sel_c35", selTr[35], 1);
    waitIdle();

    // Reset mid-div
    clearCfg(); offA = 0; kA = 1'b1; bA = 32'd7; rstFrom = 20; rstTo = 22;
    run(40);
    chk("rst_busy_c19", bzTr[19], 1);
    chk("rst_sel_c19", selTr[19], 1);
    chk("rst_busy_c20", bzTr[20], 0);
    chk("rst_sel_c20", selTr[20], 0);
    chk("rst_ready_c20", rdTr[20], 0);
    chk("rst_ready_c23", rdTr[23], 1);
    chk("rst_no_write", $countones(wrTr), 0);
    chk("rst_no_done", $countones(dnTr), 0);
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

Sequencing controller for the shared multiply/divide resources of the multicycle CPU. It accepts one mult/div operation at a time from the main control unit and drives the start pulses for the iterative mult and div units. It counts each unit's fixed latency, then commits the result into HI/LO by driving the write enables and HI/LO source selects. It also checks for divide-by-zero before a division starts and stalls mfhi/mflo reads while HI/LO is not yet valid.

## Interface
- LAT_MULT, 32, cycles from mult start pulse to valid mult outputs (≥2)
- LAT_DIV, 33, cycles from div start pulse to valid div outputs (≥2)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  control unit requests an operation
- op_kind  in  1  0 = mult, 1 = div
- op_b  in  32  divisor / second operand (register B), sampled at accept
- op_ready  out  1  operation accepted when op_valid & op_ready
- abort  in  1  cancel in-flight operation (exception elsewhere)
- hilo_read_req  in  1  control unit wants to read HI or LO
- mult_start  out  1  one-cycle start pulse to the mult unit
- div_start  out  1  one-cycle start pulse to the div unit
- hi_write  out  1  HI register write enable
- lo_write  out  1  LO register write enable
- hilo_sel  out  1  muxHi/muxLo select: 0 = mult outputs, 1 = div outputs
- div_by_zero  out  1  one-cycle exception request
- done  out  1  one-cycle completion pulse, coincident with the HI/LO write
- busy  out  1  state ≠ IDLE
- hilo_stall  out  1  hilo_read_req & busy

## Operation
- FSM states: IDLE, START, RUN, WRITE, EXC.
- IDLE:
  - op_ready = !abort.
  - On accept: latch op_kind.
  - If op_kind = 1 and op_b = 0, go to EXC.
  - Otherwise go to START.
- START:
  - Assert mult_start (kind 0) or div_start (kind 1).
  - Load the counter with LAT−1 of the selected unit.
  - Go to RUN.
- RUN:
  - Decrement the counter each cycle.
  - When the counter = 1, go to WRITE.
- WRITE:
  - hi_write = lo_write = done = 1.
  - hilo_sel = latched kind.
  - Go to IDLE.
- EXC:
  - div_by_zero = 1.
  - No start pulse, no writes.
  - Go to IDLE.
- abort:
  - In any non-IDLE state, the next state is IDLE.
  - Same-cycle start, write, done and div_by_zero are suppressed (gated combinationally).
  - In IDLE, abort blocks acceptance only.
- hilo_sel holds the latched kind in all states; it is 0 after reset.
- Counter width: $clog2(max(LAT_MULT, LAT_DIV)+1).
- The counter is compared as unsigned; no wrap-around is possible because RUN exits at 1.
- Reset: state IDLE, counter 0, latched kind 0, every output 0.
  - op_ready becomes 1 on the first cycle after reset is released, unless abort is asserted.
- Reset mid-operation returns to IDLE immediately, with no write and no done.

## Timing
- Latencies are measured from the accept cycle, cycle 0.
- Start pulse in cycle 1.
- WRITE/done in cycle 1+LAT:
  - cycle 33 for mult with defaults;
  - cycle 34 for div with defaults.
- busy spans cycles 1 … 1+LAT inclusive.
- The next op can be accepted in cycle 2+LAT (back-to-back, no bubble beyond IDLE).
- Divide-by-zero:
  - div_by_zero is asserted in cycle 1;
  - busy = 1 in cycle 1;
  - op_ready = 1 again in cycle 2.
- hilo_stall is asserted through the WRITE cycle inclusive.
  - A read in cycle 2+LAT sees the new HI/LO.
- All outputs are Moore-decoded from state, except three:
  - op_ready and hilo_stall are combinational on their inputs;
  - the abort gating on start, write, done and div_by_zero is combinational.

## Structure
- Shared package cpu_pkg holds:
  - the state enum hilo_state_t (IDLE, START, RUN, WRITE, EXC);
  - the constants HILO_SEL_MULT = 1'b0 and HILO_SEL_DIV = 1'b1.
- The block is a single module with no sub-module; the counter and FSM are inline.

## Test plan
- Mult happy path: mult with op_b = 5, op_valid at cycle 0.
  - mult_start = 1 only in cycle 1.
  - hi_write = lo_write = done = 1 with hilo_sel = 0 only in cycle 33.
  - busy in cycles 1–33; op_ready again in cycle 34.
- Div happy path: div with op_b = 7.
  - div_start in cycle 1.
  - Write and done with hilo_sel = 1 in cycle 34.
  - mult_start never asserted.
- Divide-by-zero: div with op_b = 0.
  - div_by_zero in cycle 1.
  - No div_start, hi_write or lo_write for 40 cycles.
  - op_ready in cycle 2.
- Abort mid-operation: abort at cycle 10 of a mult.
  - IDLE in cycle 11.
  - No hi_write or done through cycle 40.
  - A new mult offered in cycle 11 gets its start pulse in cycle 12.
- Read interlock: hilo_read_req held from cycle 5 of a mult.
  - hilo_stall = 1 in cycles 5–33, 0 in cycle 34.
  - Check again with abort asserted in the WRITE cycle: no write occurs.
- Reset mid-operation: reset asserted at cycle 20 of a div.
  - All outputs go to 0 immediately, while reset is still held.
  - After release: op_ready = 1; no done or hi_write appears later.
